// File: rtl/btn_pkg.sv
// Shared types and defaults for the button event generator.
package btn_pkg;

  // FSM state; the 2'b11 encoding is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    PRESSED   = 2'b01,
    LONG_HELD = 2'b10
  } btn_state_t;

  localparam int unsigned DEF_CNT_W    = 8;
  localparam int unsigned DEF_LONG_CYC = 32;
  localparam int unsigned DEF_RPT_CYC  = 8;

  // True while the button is considered held (any non-idle state).
  function automatic logic state_active(input btn_state_t s);
    return (s == PRESSED) || (s == LONG_HELD);
  endfunction

endpackage

// File: rtl/btn_tick_cnt.sv
// Interval counter shared by the long-press and repeat timers.
// tc is registered: it is high in the cycle where the count equals the
// terminal value that was presented alongside the update producing it.
module btn_tick_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tc_d;

  // Next count: clear wins over enable; hold otherwise.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    // term belongs to the state the counter is entering, so compare the next value.
    tc_d = (cnt_d == term);
  end

  // Count and terminal flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      tc    <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc    <= tc_d;
    end
  end

endmodule

// File: rtl/btn_event_gen.sv
// Button event generator: turns a debounced level into single-cycle press,
// release, long-press and auto-repeat pulses plus a held level.
// Optional feature macro: BTN_REPEAT_EN (enables repeat_p in LONG_HELD).
module btn_event_gen
  import btn_pkg::*;
#(
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned LONG_CYC = DEF_LONG_CYC,
  parameter int unsigned RPT_CYC  = DEF_RPT_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic db_in,
  output logic press,
  output logic release_p,
  output logic long_press,
  output logic repeat_p,
  output logic held
);

  localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] RPT_TERM  = CNT_W'(RPT_CYC - 1);

  btn_state_t       state_q, state_d;
  logic             db_prev;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             held_q, held_d;
  logic             cnt_clr, cnt_en, cnt_tc;
  logic [CNT_W-1:0] cnt_term;

  btn_tick_cnt #(
    .CNT_W (CNT_W)
  ) u_tick_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .term (cnt_term),
    .tc   (cnt_tc)
  );

  // Next state, counter control and event decisions; release has priority.
  always_comb begin
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (db_in && !db_prev) begin
          press_d = 1'b1;
          state_d = PRESSED;
        end
      end

      PRESSED: begin
        if (!db_in) begin
          release_d = 1'b1;
          cnt_clr   = 1'b1;
          state_d   = IDLE;
        end else if (cnt_tc) begin
          long_d  = 1'b1;
          cnt_clr = 1'b1;
          state_d = LONG_HELD;
        end else begin
          cnt_en = 1'b1;
        end
      end

      LONG_HELD: begin
        if (!db_in) begin
          release_d = 1'b1;
          cnt_clr   = 1'b1;
          state_d   = IDLE;
        end
`ifdef BTN_REPEAT_EN
        else if (cnt_tc) begin
          repeat_d = 1'b1;
          cnt_clr  = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
`else
        else begin
          // Repeat disabled: just wait for release with the counter parked at 0.
          cnt_clr = 1'b1;
        end
`endif
      end

      default: begin
        // Illegal encoding: back to IDLE silently.
        cnt_clr = 1'b1;
        state_d = IDLE;
      end
    endcase

    held_d = state_active(state_d);

    // Terminal value for the interval the counter is about to time.
    cnt_term = (state_d == LONG_HELD) ? RPT_TERM : LONG_TERM;
  end

  // State, edge-detect history and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      db_prev   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      db_prev   <= db_in;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
    end
  end

  assign press      = press_q;
  assign release_p  = release_q;
  assign long_press = long_q;
  assign repeat_p   = repeat_q;
  assign held       = held_q;

endmodule
